// File: rtl/keypad_scanner_if.sv
// Keypad pin bundle plus accepted-key outputs.
// The scanner drives columns and reports keys; the keypad side drives rows.
interface keypad_scanner_if;
   logic [3:0] rows;
   logic [5:0] cols;
   logic       newkey;
   logic [4:0] keycode;
   logic       key_held;

   modport master (
      output rows,
      input  cols,
      input  newkey,
      input  keycode,
      input  key_held
   );

   modport slave (
      input  rows,
      output cols,
      output newkey,
      output keycode,
      output key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 6x4 keypad scanner: column scan, per-key debounce on press and release,
// single-key lockout while a key is held.
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   keypad_scanner_if.slave   kp
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE);
   localparam logic [DW-1:0] DLAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_HELD,
      S_RELEASE
   } state_t;

   state_t          state, nxt;
   logic [3:0]      s1, s2;
   logic [2:0]      col, ncol;
   logic [1:0]      row, hrow;
   logic [DW-1:0]   dcnt;
   logic [CW-1:0]   cnt;
   logic            newkey_q;
   logic [4:0]      keycode_q;
   logic [3:0]      mask, low;
   logic            hit, rlow, dwell_end, cnt_end;

   function automatic logic [4:0] keymap(
      input logic [2:0] c,
      input logic [1:0] r
   );
      logic [4:0] k;
      k = 5'b00000;
      if (!c[2]) begin
         k = {1'b1, r, c[1:0]};
      end else if (c == 3'd4) begin
         case (r)
            2'd0:    k = 5'b01001;
            2'd1:    k = 5'b00001;
            2'd2:    k = 5'b01010;
            default: k = 5'b00100;
         endcase
      end else begin
         case (r)
            2'd0:    k = 5'b01011;
            2'd1:    k = 5'b00011;
            default: k = 5'b00000;
         endcase
      end
      return k;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 4'hF;
         s2 <= 4'hF;
      end else begin
         s1 <= kp.rows;
         s2 <= s1;
      end
   end

   // Column 5 has only two wired rows; the others must never trigger.
   always_comb begin
      mask = (col == 3'd5) ? 4'b0011 : 4'b1111;
      low  = ~s2 & mask;
      hit  = |low;
      hrow = 2'd3;
      if (low[2]) hrow = 2'd2;
      if (low[1]) hrow = 2'd1;
      if (low[0]) hrow = 2'd0;
      rlow      = ~s2[row];
      dwell_end = (dcnt == DLAST);
      cnt_end   = (cnt == CLAST);
      ncol      = (col == 3'd5) ? 3'd0 : col + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_SCAN;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         S_SCAN:
            if (dwell_end && hit) nxt = S_DEBOUNCE;
         S_DEBOUNCE:
            if (!rlow)        nxt = S_SCAN;
            else if (cnt_end) nxt = S_HELD;
         S_HELD:
            if (!rlow) nxt = S_RELEASE;
         S_RELEASE:
            if (rlow)         nxt = S_HELD;
            else if (cnt_end) nxt = S_SCAN;
         default: nxt = S_SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= 3'd0;
         row       <= 2'd0;
         dcnt      <= '0;
         cnt       <= '0;
         newkey_q  <= 1'b0;
         keycode_q <= 5'b00000;
      end else begin
         newkey_q <= 1'b0;
         unique case (state)
            S_SCAN: begin
               if (dwell_end) begin
                  dcnt <= '0;
                  if (hit) begin
                     row <= hrow;
                     cnt <= '0;
                  end else begin
                     col <= ncol;
                  end
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            S_DEBOUNCE: begin
               if (!rlow) begin
                  col  <= ncol;
                  dcnt <= '0;
                  cnt  <= '0;
               end else if (cnt_end) begin
                  cnt       <= '0;
                  newkey_q  <= 1'b1;
                  keycode_q <= keymap(col, row);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HELD: cnt <= '0;
            S_RELEASE: begin
               if (rlow) begin
                  cnt <= '0;
               end else if (cnt_end) begin
                  cnt  <= '0;
                  col  <= 3'd0;
                  dcnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   always_comb begin
      kp.cols     = ~(6'b000001 << col);
      kp.newkey   = newkey_q;
      kp.keycode  = keycode_q;
      kp.key_held = (state == S_HELD) || (state == S_RELEASE);
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=8.
// Keypad matrix model feeds rows; a monitor scores every newkey pulse.
module tb_keypad_scanner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   keypad_scanner_if kp();

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .kp(kp)
   );

   logic [3:0] pressed [6] = '{default: 4'h0};
   logic [3:0] rowv;
   int tests = 0;
   int fails = 0;
   logic [4:0] expq [$];

   always_comb begin
      rowv = 4'hF;
      for (int c = 0; c < 6; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[c][r] && !kp.cols[c]) rowv[r] = 1'b0;
   end
   assign kp.rows = rowv;

   function automatic logic [5:0] colv(input int c);
      logic [5:0] one;
      one = 6'b000001;
      return ~(one << c);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_pulse(input int n, input string nm);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (kp.newkey) begin
            seen = 1'b1;
            break;
         end
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   // Lands on the first negedge of column c's dwell.
   task automatic wait_col(input int c, input int n, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (kp.cols != colv(c)) break;
         @(negedge clk);
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (kp.cols == colv(c)) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, 32'(ok), 32'd1);
   endtask

   initial begin : monitor
      logic prev_nk;
      logic [4:0] e;
      prev_nk = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_nk = 1'b0;
         end else begin
            if (kp.newkey) begin
               tests++;
               if (prev_nk) begin
                  fails++;
                  $display("FAIL pulse_width: newkey high 2 clocks, required 1");
               end else if (expq.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_pulse: keycode %b, required no pulse",
                           kp.keycode);
               end else begin
                  e = expq.pop_front();
                  if (kp.keycode !== e || kp.key_held !== 1'b1) begin
                     fails++;
                     $display("FAIL pulse_key: keycode %b held %b, required %b held 1",
                              kp.keycode, kp.key_held, e);
                  end
               end
            end
            prev_nk = kp.newkey;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      // reset values and free-running scan
      tick(3);
      chk("rst_cols", 32'(kp.cols), 32'h3E);
      chk("rst_newkey", 32'(kp.newkey), 32'd0);
      chk("rst_keycode", 32'(kp.keycode), 32'd0);
      chk("rst_held", 32'(kp.key_held), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 24; k++) begin
         chk("scan_cols", 32'(kp.cols), 32'(colv((k / 4) % 6)));
         tick(1);
      end

      // hex 6, long hold, clean release
      expq.push_back(5'b10110);
      pressed[2][1] = 1'b1;
      wait_pulse(200, "hex6_pulse");
      tick(40);
      chk("hex6_held", 32'(kp.key_held), 32'd1);
      pressed[2][1] = 1'b0;
      tick(10);
      chk("hex6_held_rel", 32'(kp.key_held), 32'd1);
      tick(1);
      chk("hex6_clear", 32'(kp.key_held), 32'd0);
      tick(20);

      // EQUALS with a 3-clock glitch first
      wait_col(4, 100, "glitch_align");
      pressed[4][3] = 1'b1;
      tick(3);
      pressed[4][3] = 1'b0;
      tick(30);
      chk("glitch_keycode", 32'(kp.keycode), 32'h16);
      expq.push_back(5'b00100);
      pressed[4][3] = 1'b1;
      wait_pulse(200, "eq_pulse");
      tick(5);
      pressed[4][3] = 1'b0;
      tick(20);
      chk("eq_keycode", 32'(kp.keycode), 32'h04);

      // hex 9 with bounce on release
      expq.push_back(5'b11001);
      pressed[1][2] = 1'b1;
      wait_pulse(200, "hex9_pulse");
      tick(5);
      pressed[1][2] = 1'b0;
      tick(3);
      pressed[1][2] = 1'b1;
      tick(2);
      chk("bounce_held", 32'(kp.key_held), 32'd1);
      pressed[1][2] = 1'b0;
      tick(10);
      chk("bounce_held_rel", 32'(kp.key_held), 32'd1);
      tick(1);
      chk("bounce_clear", 32'(kp.key_held), 32'd0);
      tick(20);

      // hex 0 held locks out BACK until released
      expq.push_back(5'b10000);
      pressed[0][0] = 1'b1;
      wait_pulse(200, "hex0_pulse");
      pressed[5][0] = 1'b1;
      tick(60);
      chk("lock_held", 32'(kp.key_held), 32'd1);
      chk("lock_keycode", 32'(kp.keycode), 32'h10);
      pressed[0][0] = 1'b0;
      expq.push_back(5'b01011);
      wait_pulse(200, "back_pulse");
      tick(1);
      chk("back_keycode", 32'(kp.keycode), 32'h0B);
      pressed[5][0] = 1'b0;
      tick(20);

      // unused col 5 / row 3 never accepted
      pressed[5][3] = 1'b1;
      wait_col(0, 100, "unused_align");
      for (int k = 0; k < 48; k++) begin
         chk("unused_cols", 32'(kp.cols), 32'(colv((k / 4) % 6)));
         tick(1);
      end
      chk("unused_keycode", 32'(kp.keycode), 32'h0B);
      pressed[5][3] = 1'b0;

      // reset during debounce of hex F, then re-detect
      rst_n = 1'b0;
      pressed[3][3] = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      rst_n = 1'b0;
      #1;
      chk("abort_cols", 32'(kp.cols), 32'h3E);
      chk("abort_newkey", 32'(kp.newkey), 32'd0);
      chk("abort_keycode", 32'(kp.keycode), 32'd0);
      chk("abort_held", 32'(kp.key_held), 32'd0);
      tick(3);
      rst_n = 1'b1;
      expq.push_back(5'b11111);
      tick(23);
      chk("hexf_early", 32'(kp.newkey), 32'd0);
      tick(1);
      chk("hexf_newkey", 32'(kp.newkey), 32'd1);
      chk("hexf_keycode", 32'(kp.keycode), 32'h1F);
      tick(1);
      chk("hexf_single", 32'(kp.newkey), 32'd0);
      pressed[3][3] = 1'b0;
      tick(30);

      chk("queue_empty", 32'(expq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
